// File: rtl/ct_ifu_spsram_1024x59_ctrl.sv
// Access controller for the 1024x59 single-port IFU SRAM: init/flush sweep,
// valid/ready request port and a 2-entry buffered read-response port.
module ct_ifu_spsram_1024x59_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 59,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  flush_req,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_busy,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {INIT, IDLE} state_t;

  localparam logic [ADDR_WIDTH:0] SWEEP_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   sweep_cnt_reg, sweep_cnt_next;
  logic                  inflight_reg, inflight_next;
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic [1:0]            count_reg;
  logic [1:0]            credit_sum;
  logic                  accept;
  logic                  fifo_clear;
  logic                  push;
  logic                  pop;

  // Outstanding reads = one possibly in the SRAM pipe plus buffered entries.
  assign credit_sum = {1'b0, inflight_reg} + count_reg;
  assign init_busy  = (state_reg == INIT);
  assign rsp_vld    = (count_reg != 2'd0);
  assign push       = inflight_reg && !fifo_clear;
  assign pop        = rsp_vld && rsp_rdy;

  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    inflight_next  = 1'b0;
    fifo_clear     = 1'b0;
    accept         = 1'b0;
    req_rdy        = 1'b0;
    sram_cen       = 1'b1;
    sram_gwen      = 1'b1;
    sram_wen       = '1;
    sram_a         = '0;
    sram_d         = '0;
    if (!cpurst) begin
      case (state_reg)
        INIT: begin
          sram_cen       = 1'b0;
          sram_gwen      = 1'b0;
          sram_wen       = '0;
          sram_a         = sweep_cnt_reg[ADDR_WIDTH-1:0];
          sram_d         = INIT_DATA;
          sweep_cnt_next = sweep_cnt_reg + 1'b1;
          if (sweep_cnt_reg == SWEEP_LAST) begin
            state_next = IDLE;
          end
        end
        IDLE: begin
          if (flush_req) begin
            state_next     = INIT;
            sweep_cnt_next = '0;
            fifo_clear     = 1'b1;
          end else begin
            req_rdy = (credit_sum < 2'd2);
            accept  = req_vld && req_rdy;
            if (accept) begin
              sram_cen = 1'b0;
              sram_a   = req_addr;
              if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask;
                sram_d    = req_wdata;
              end else begin
                inflight_next = 1'b1;
              end
            end
          end
        end
        default: state_next = INIT;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_reg     <= INIT;
      sweep_cnt_reg <= '0;
      inflight_reg  <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
    end else begin
      state_reg     <= state_next;
      sweep_cnt_reg <= sweep_cnt_next;
      inflight_reg  <= inflight_next;
      if (fifo_clear) begin
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
        count_reg  <= 2'd0;
      end else begin
        if (push) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // Response buffer storage; sram_q is only meaningful in the inflight cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [DATA_WIDTH-1:0] entry_reg;
    always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
        entry_reg <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        entry_reg <= sram_q;
      end
    end
  end

  assign rsp_data = rd_ptr_reg ? g_fifo[1].entry_reg : g_fifo[0].entry_reg;

endmodule
